// File: rtl/textmode_console_pkg.sv
// Shared definitions for the textmode console front end.
//   - tram word layout (colour slots packed down from the MSB, code point at the LSBs)
//   - control code points handled by the console
//   - FSM state encoding
package textmode_console_pkg;

    // Code point occupies [UCP_W-1:0] of every tram word.
    localparam int UCP_W = 21;

    // Colour fields are packed from the top of the word downwards:
    // slot s occupies [WORD-1-s*CIDXW -: CIDXW].
    localparam int BG_SLOT = 0;
    localparam int FG_SLOT = 1;

    localparam logic [UCP_W-1:0] UCP_BS    = 21'h08;
    localparam logic [UCP_W-1:0] UCP_LF    = 21'h0A;
    localparam logic [UCP_W-1:0] UCP_CR    = 21'h0D;
    localparam logic [UCP_W-1:0] UCP_SPACE = 21'h20;

    localparam logic [1:0] ST_CLEAR_ALL  = 2'd0;
    localparam logic [1:0] ST_READY      = 2'd1;
    localparam logic [1:0] ST_CLEAR_LINE = 2'd2;

endpackage

// File: rtl/textmode_console_tram_addr_wrap.sv
// Modular adder for tram addresses: y = (a + b) mod DEPTH.
// Both operands are assumed already below DEPTH, so one conditional
// subtract on the ADDRW+1 bit sum is enough.
//   a, b : operands (ADDRW)
//   y    : wrapped sum (ADDRW)
module tram_addr_wrap #(
    parameter int ADDRW = 14,
    parameter int DEPTH = 9600
) (
    input  logic [ADDRW-1:0] a,
    input  logic [ADDRW-1:0] b,
    output logic [ADDRW-1:0] y
);
    logic [ADDRW:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (ADDRW+1)'(DEPTH)) begin
            sum = sum - (ADDRW+1)'(DEPTH);
        end
        y = sum[ADDRW-1:0];
    end
endmodule

// File: rtl/textmode_console.sv
// Character-stream front end: turns (code point, fg, bg) commands into tram
// writes, tracks the cursor, wraps lines, handles LF/CR/BS and scrolls by
// advancing scroll_offs and blanking the newly exposed bottom line.
//   clk_sys, rst_sys          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake; cmd_ucp/cmd_fg/cmd_bg payload
//   clear                     : one-cycle request to blank the whole screen
//   text_hres, text_vres      : screen size in characters
//   tram_we/tram_addr/tram_din: registered tram write port
//   scroll_offs               : tram address of the top-left character
//   cur_x, cur_y              : cursor column / row
module textmode_console
    import textmode_console_pkg::*;
#(
    parameter int WORD       = 32,
    parameter int ADDRW      = 14,
    parameter int CIDXW      = 4,
    parameter int TRAM_DEPTH = 9600
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [20:0]       cmd_ucp,
    input  logic [CIDXW-1:0]  cmd_fg,
    input  logic [CIDXW-1:0]  cmd_bg,
    input  logic              clear,
    input  logic [ADDRW-1:0]  text_hres,
    input  logic [ADDRW-1:0]  text_vres,
    output logic              tram_we,
    output logic [ADDRW-1:0]  tram_addr,
    output logic [WORD-1:0]   tram_din,
    output logic [ADDRW-1:0]  scroll_offs,
    output logic [ADDRW-1:0]  cur_x,
    output logic [ADDRW-1:0]  cur_y
);
    localparam logic [ADDRW-1:0] ONE = ADDRW'(1);

    function automatic logic [WORD-1:0] make_word(input logic [CIDXW-1:0] bg,
                                                  input logic [CIDXW-1:0] fg,
                                                  input logic [UCP_W-1:0] ucp);
        logic [WORD-1:0] w;
        w = '0;
        w[WORD-1-BG_SLOT*CIDXW -: CIDXW] = bg;
        w[WORD-1-FG_SLOT*CIDXW -: CIDXW] = fg;
        w[UCP_W-1:0] = ucp;
        return w;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [ADDRW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [ADDRW-1:0] line_addr_q, line_addr_d;
    logic [ADDRW-1:0] scroll_q, scroll_d;
    logic [ADDRW-1:0] clr_addr_q, clr_addr_d;
    logic [ADDRW-1:0] clr_col_q, clr_col_d, clr_row_q, clr_row_d;
    logic [CIDXW-1:0] fg_q, fg_d, bg_q, bg_d;
    logic             tram_we_q, tram_we_d;
    logic [ADDRW-1:0] tram_addr_q, tram_addr_d;
    logic [WORD-1:0]  tram_din_q, tram_din_d;

    logic [ADDRW-1:0] wr_addr, next_line, next_scroll, clr_next;
    logic             dims_ok, accept, new_line;
    logic [WORD-1:0]  blank_word;

    tram_addr_wrap #(.ADDRW(ADDRW), .DEPTH(TRAM_DEPTH)) u_wr_addr (
        .a(line_addr_q), .b(cx_q),      .y(wr_addr));
    tram_addr_wrap #(.ADDRW(ADDRW), .DEPTH(TRAM_DEPTH)) u_next_line (
        .a(line_addr_q), .b(text_hres), .y(next_line));
    tram_addr_wrap #(.ADDRW(ADDRW), .DEPTH(TRAM_DEPTH)) u_next_scroll (
        .a(scroll_q),    .b(text_hres), .y(next_scroll));
    tram_addr_wrap #(.ADDRW(ADDRW), .DEPTH(TRAM_DEPTH)) u_clr_next (
        .a(clr_addr_q),  .b(ONE),       .y(clr_next));

    assign dims_ok    = (text_hres != '0) && (text_vres != '0);
    // clear has priority, so ready already drops in the cycle it is raised
    assign cmd_ready  = (state_q == ST_READY) && !clear && dims_ok;
    assign accept     = cmd_valid && cmd_ready;
    assign blank_word = make_word(bg_q, fg_q, UCP_SPACE);

    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        line_addr_d = line_addr_q;
        scroll_d    = scroll_q;
        clr_addr_d  = clr_addr_q;
        clr_col_d   = clr_col_q;
        clr_row_d   = clr_row_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        tram_we_d   = 1'b0;
        tram_addr_d = tram_addr_q;
        tram_din_d  = tram_din_q;
        new_line    = 1'b0;

        case (state_q)
            ST_CLEAR_ALL: begin
                if (!dims_ok) begin
                    state_d = ST_READY;
                end else begin
                    tram_we_d   = 1'b1;
                    tram_addr_d = clr_addr_q;
                    tram_din_d  = blank_word;
                    clr_addr_d  = clr_next;
                    if (clr_col_q == text_hres - ONE) begin
                        clr_col_d = '0;
                        if (clr_row_q == text_vres - ONE) begin
                            state_d = ST_READY;
                        end else begin
                            clr_row_d = clr_row_q + ONE;
                        end
                    end else begin
                        clr_col_d = clr_col_q + ONE;
                    end
                end
                // Screen is rebuilt from the origin whatever the exit path.
                if (state_d == ST_READY) begin
                    cx_d        = '0;
                    cy_d        = '0;
                    line_addr_d = '0;
                    scroll_d    = '0;
                end
            end

            ST_CLEAR_LINE: begin
                if (!dims_ok) begin
                    state_d = ST_READY;
                end else begin
                    tram_we_d   = 1'b1;
                    tram_addr_d = clr_addr_q;
                    tram_din_d  = blank_word;
                    clr_addr_d  = clr_next;
                    if (clr_col_q == text_hres - ONE) begin
                        state_d = ST_READY;
                    end else begin
                        clr_col_d = clr_col_q + ONE;
                    end
                end
            end

            ST_READY: begin
                if (clear) begin
                    state_d    = ST_CLEAR_ALL;
                    clr_addr_d = '0;
                    clr_col_d  = '0;
                    clr_row_d  = '0;
                end else if (accept) begin
                    fg_d = cmd_fg;
                    bg_d = cmd_bg;
                    case (cmd_ucp)
                        UCP_LF: begin
                            cx_d     = '0;
                            new_line = 1'b1;
                        end
                        UCP_CR: cx_d = '0;
                        UCP_BS: if (cx_q != '0) cx_d = cx_q - ONE;
                        default: begin
                            tram_we_d   = 1'b1;
                            tram_addr_d = wr_addr;
                            tram_din_d  = make_word(cmd_bg, cmd_fg, cmd_ucp);
                            if (cx_q == text_hres - ONE) begin
                                cx_d     = '0;
                                new_line = 1'b1;
                            end else begin
                                cx_d = cx_q + ONE;
                            end
                        end
                    endcase
                    if (new_line) begin
                        line_addr_d = next_line;
                        if (cy_q != text_vres - ONE) begin
                            cy_d = cy_q + ONE;
                        end else begin
                            // Bottom row: move the window down one line and
                            // blank the line that just came into view.
                            scroll_d   = next_scroll;
                            clr_addr_d = next_line;
                            clr_col_d  = '0;
                            state_d    = ST_CLEAR_LINE;
                        end
                    end
                end
            end

            default: state_d = ST_CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q     <= ST_CLEAR_ALL;
            cx_q        <= '0;
            cy_q        <= '0;
            line_addr_q <= '0;
            scroll_q    <= '0;
            clr_addr_q  <= '0;
            clr_col_q   <= '0;
            clr_row_q   <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            tram_we_q   <= 1'b0;
            tram_addr_q <= '0;
            tram_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            line_addr_q <= line_addr_d;
            scroll_q    <= scroll_d;
            clr_addr_q  <= clr_addr_d;
            clr_col_q   <= clr_col_d;
            clr_row_q   <= clr_row_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            tram_we_q   <= tram_we_d;
            tram_addr_q <= tram_addr_d;
            tram_din_q  <= tram_din_d;
        end
    end

    assign tram_we     = tram_we_q;
    assign tram_addr   = tram_addr_q;
    assign tram_din    = tram_din_q;
    assign scroll_offs = scroll_q;
    assign cur_x       = cx_q;
    assign cur_y       = cy_q;
endmodule

// File: tb/tb_textmode_console.sv
// Directed bench for textmode_console on a 4x3 screen in a 16-entry tram.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_textmode_console;
    localparam int WORD = 32, ADDRW = 14, CIDXW = 4, DEPTH = 16;

    logic              clk_sys = 1'b0;
    logic              rst_sys = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [20:0]       cmd_ucp = '0;
    logic [CIDXW-1:0]  cmd_fg = '0, cmd_bg = '0;
    logic              clear = 1'b0;
    logic [ADDRW-1:0]  text_hres = 14'd4, text_vres = 14'd3;
    logic              tram_we;
    logic [ADDRW-1:0]  tram_addr, scroll_offs, cur_x, cur_y;
    logic [WORD-1:0]   tram_din;

    int n_tests = 0;
    int n_fail  = 0;

    textmode_console #(.WORD(WORD), .ADDRW(ADDRW), .CIDXW(CIDXW), .TRAM_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ucp(cmd_ucp), .cmd_fg(cmd_fg), .cmd_bg(cmd_bg),
        .clear(clear), .text_hres(text_hres), .text_vres(text_vres),
        .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
        .scroll_offs(scroll_offs), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for one rising edge, return at the next falling edge.
    task automatic send(input logic [20:0] u, input logic [3:0] f, input logic [3:0] b);
        cmd_ucp = u; cmd_fg = f; cmd_bg = b; cmd_valid = 1'b1;
        @(posedge clk_sys);
        #1 cmd_valid = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] din);
        chk({tag, " we"},   tram_we,   1);
        chk({tag, " addr"}, tram_addr, addr);
        chk({tag, " din"},  tram_din,  din);
    endtask

    // Twelve blank writes at 0..11; ready returns alongside the last one.
    task automatic full_clear_chk(input string tag, input logic [31:0] blank);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            write_chk(tag, i, blank);
            chk({tag, " ready"}, cmd_ready, (i == 11) ? 1 : 0);
        end
        chk({tag, " cur_x"}, cur_x, 0);
        chk({tag, " cur_y"}, cur_y, 0);
        chk({tag, " scroll"}, scroll_offs, 0);
    endtask

    task automatic line_blank_chk(input string tag, input int base, input logic [31:0] blank);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            write_chk(tag, (base + i) % DEPTH, blank);
            chk({tag, " ready"}, cmd_ready, (i == 3) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst we", tram_we, 0);
        chk("rst addr", tram_addr, 0);
        chk("rst din", tram_din, 0);
        chk("rst scroll", scroll_offs, 0);
        chk("rst cx", cur_x, 0);
        chk("rst cy", cur_y, 0);
        chk("rst ready", cmd_ready, 0);
        rst_sys = 1'b0;
        full_clear_chk("init clr", 32'h0000_0020);

        // First printable
        send(21'h41, 4'hF, 4'h1);
        write_chk("A", 0, 32'h1F00_0041);
        chk("A cx", cur_x, 1);

        // Fill row 0, wrap to row 1
        send(21'h42, 4'hF, 4'h1); write_chk("B", 1, 32'h1F00_0042);
        send(21'h43, 4'hF, 4'h1); write_chk("C", 2, 32'h1F00_0043);
        send(21'h44, 4'hF, 4'h1); write_chk("D", 3, 32'h1F00_0044);
        chk("wrap cx", cur_x, 0);
        chk("wrap cy", cur_y, 1);
        send(21'h45, 4'hF, 4'h1); write_chk("E", 4, 32'h1F00_0045);
        chk("E cx", cur_x, 1);

        // LF to row 2, no write
        send(21'h0A, 4'h2, 4'h3);
        chk("lf1 we", tram_we, 0);
        chk("lf1 cx", cur_x, 0);
        chk("lf1 cy", cur_y, 2);

        // LF at bottom: scroll, blank 12..15
        send(21'h0A, 4'h2, 4'h3);
        chk("scr1 offs", scroll_offs, 4);
        chk("scr1 ready", cmd_ready, 0);
        chk("scr1 we", tram_we, 0);
        chk("scr1 cy", cur_y, 2);
        line_blank_chk("scr1 blank", 12, 32'h3200_0020);

        // Second scroll wraps the line address
        send(21'h0A, 4'h2, 4'h3);
        chk("scr2 offs", scroll_offs, 8);
        line_blank_chk("scr2 blank", 0, 32'h3200_0020);
        send(21'h5A, 4'h1, 4'h0);
        write_chk("Z", 0, 32'h0100_005A);
        chk("Z cx", cur_x, 1);

        // Backspace / carriage return
        send(21'h08, 4'h1, 4'h0);
        chk("bs1 we", tram_we, 0);
        chk("bs1 cx", cur_x, 0);
        send(21'h08, 4'h1, 4'h0);
        chk("bs0 we", tram_we, 0);
        chk("bs0 cx", cur_x, 0);
        send(21'h61, 4'h1, 4'h0); write_chk("a", 0, 32'h0100_0061);
        send(21'h62, 4'h1, 4'h0); write_chk("b", 1, 32'h0100_0062);
        send(21'h08, 4'h1, 4'h0);
        chk("bs2 cx", cur_x, 1);
        chk("bs2 cy", cur_y, 2);
        send(21'h0D, 4'h7, 4'h8);
        chk("cr we", tram_we, 0);
        chk("cr cx", cur_x, 0);

        // clear together with a command: command dropped, colours kept
        clear = 1'b1; cmd_valid = 1'b1; cmd_ucp = 21'h41; cmd_fg = 4'h5; cmd_bg = 4'h6;
        #1 chk("clr ready", cmd_ready, 0);
        @(posedge clk_sys);
        #1 clear = 1'b0; cmd_valid = 1'b0;
        @(negedge clk_sys);
        chk("clr no write", tram_we, 0);
        full_clear_chk("clr", 32'h8700_0020);

        // Reset in the middle of a line blank
        send(21'h0A, 4'h0, 4'h0);
        send(21'h0A, 4'h0, 4'h0);
        send(21'h0A, 4'h0, 4'h0);
        chk("scr3 offs", scroll_offs, 4);
        @(posedge clk_sys);
        @(negedge clk_sys);
        write_chk("scr3 first", 12, 32'h0000_0020);
        rst_sys = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("midrst we", tram_we, 0);
        chk("midrst scroll", scroll_offs, 0);
        chk("midrst ready", cmd_ready, 0);
        rst_sys = 1'b0;
        full_clear_chk("midrst clr", 32'h0000_0020);

        // Zero width screen: nothing accepted
        text_hres = '0;
        #1 chk("h0 ready", cmd_ready, 0);
        send(21'h41, 4'h1, 4'h1);
        chk("h0 we", tram_we, 0);
        chk("h0 cx", cur_x, 0);
        text_hres = 14'd4;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
